// File: rtl/hazard_unit_mw.sv
// Hazard unit for the 5-stage RISC-V pipeline: M/W forwarding, load-use stall, branch flush,
// and a data-memory wait FSM with timeout. Define HAZARD_PERF_CNT_EN to add stall/flush counters.
module hazard_unit_mw #(
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TO_W        = 8,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] Rs1D,
   input  logic [REG_ADDR_W-1:0] Rs2D,
   input  logic [REG_ADDR_W-1:0] Rs1E,
   input  logic [REG_ADDR_W-1:0] Rs2E,
   input  logic [REG_ADDR_W-1:0] RdE,
   input  logic [REG_ADDR_W-1:0] RdM,
   input  logic [REG_ADDR_W-1:0] RdW,
   input  logic                  PCSrcE,
   input  logic                  ResultSrcEb0,
   input  logic                  RegWriteM,
   input  logic                  RegWriteW,
   input  logic                  mem_req_m,
   input  logic                  mem_ready_m,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  StallE,
   output logic                  StallM,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  FlushW,
   output logic                  mem_timeout,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   typedef enum logic [1:0] {
      RUN  = 2'b00,
      WAIT = 2'b01,
      ERR  = 2'b10
   } stateT;

   stateT           state, nextState;
   logic [TO_W-1:0] waitCnt, nextWaitCnt;
   logic            timeoutFlag;
   logic            memWait, lwStall, freeze;

   assign memWait = mem_req_m & ~mem_ready_m;
   assign lwStall = ResultSrcEb0 & (RdE != '0) & ((Rs1D == RdE) | (Rs2D == RdE));
   assign freeze  = memWait | (state == ERR);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         waitCnt     <= '0;
         timeoutFlag <= 1'b0;
      end else begin
         state   <= nextState;
         waitCnt <= nextWaitCnt;
         if (nextState == ERR) timeoutFlag <= 1'b1;
      end
   end

   always_comb begin
      nextState   = state;
      nextWaitCnt = waitCnt;
      case (state)
         RUN: begin
            if (memWait) begin
               nextState   = WAIT;
               nextWaitCnt = TO_W'(1);
            end
         end
         WAIT: begin
            if (mem_ready_m) begin
               nextState   = RUN;
               nextWaitCnt = '0;
            end else if ((MEM_TIMEOUT != 0) && (waitCnt == TO_W'(MEM_TIMEOUT))) begin
               nextState = ERR;
            end else begin
               nextWaitCnt = waitCnt + TO_W'(1);
            end
         end
         ERR:     nextState = ERR;
         default: nextState = RUN;
      endcase
   end

   // Every output is forced low while reset is held, independent of the clock.
   always_comb begin
      ForwardAE   = 2'b00;
      ForwardBE   = 2'b00;
      StallF      = 1'b0;
      StallD      = 1'b0;
      StallE      = 1'b0;
      StallM      = 1'b0;
      FlushD      = 1'b0;
      FlushE      = 1'b0;
      FlushW      = 1'b0;
      mem_timeout = 1'b0;
      if (reset) begin
         if ((Rs1E == RdM) && RegWriteM && (Rs1E != '0))      ForwardAE = 2'b10;
         else if ((Rs1E == RdW) && RegWriteW && (Rs1E != '0)) ForwardAE = 2'b01;
         if ((Rs2E == RdM) && RegWriteM && (Rs2E != '0))      ForwardBE = 2'b10;
         else if ((Rs2E == RdW) && RegWriteW && (Rs2E != '0)) ForwardBE = 2'b01;
         mem_timeout = timeoutFlag;
         if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else begin
            StallF = lwStall & ~PCSrcE;
            StallD = lwStall & ~PCSrcE;
            FlushD = PCSrcE;
            FlushE = PCSrcE | lwStall;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stallCnt, flushCnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (StallF && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
         if (PCSrcE && !freeze && (flushCnt != '1)) flushCnt <= flushCnt + CNT_W'(1);
      end
   end

   assign stall_cnt = stallCnt;
   assign flush_cnt = flushCnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mw.sv
// Directed bench for hazard_unit_mw (MEM_TIMEOUT=4, CNT_W=4): forwarding, load-use,
// branch flush, memory-wait freeze, timeout, async reset and counter saturation.
module tb_hazard_unit_mw;

   localparam logic [6:0] IDLE = 7'b0000000;
   localparam logic [6:0] LW   = 7'b1100010;
   localparam logic [6:0] BR   = 7'b0000110;
   localparam logic [6:0] FRZ  = 7'b1111001;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       PCSrcE, ResultSrcEb0, RegWriteM, RegWriteW, mem_req_m, mem_ready_m;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
   logic [3:0] stall_cnt, flush_cnt;

   int         nAssert = 0;
   int         nFail   = 0;
   logic [6:0] expCtl  = IDLE;
   logic [3:0] expStallCnt, expFlushCnt;

   hazard_unit_mw #(
      .REG_ADDR_W (5),
      .MEM_TIMEOUT(4),
      .TO_W       (8),
      .CNT_W      (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .Rs1D        (Rs1D),
      .Rs2D        (Rs2D),
      .Rs1E        (Rs1E),
      .Rs2E        (Rs2E),
      .RdE         (RdE),
      .RdM         (RdM),
      .RdW         (RdW),
      .PCSrcE      (PCSrcE),
      .ResultSrcEb0(ResultSrcEb0),
      .RegWriteM   (RegWriteM),
      .RegWriteW   (RegWriteW),
      .mem_req_m   (mem_req_m),
      .mem_ready_m (mem_ready_m),
      .ForwardAE   (ForwardAE),
      .ForwardBE   (ForwardBE),
      .StallF      (StallF),
      .StallD      (StallD),
      .StallE      (StallE),
      .StallM      (StallM),
      .FlushD      (FlushD),
      .FlushE      (FlushE),
      .FlushW      (FlushW),
      .mem_timeout (mem_timeout),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   always #5 clock = ~clock;

   // Counter reference: counts the cycles the bench expects StallF / branch flush.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         expStallCnt <= 4'd0;
         expFlushCnt <= 4'd0;
      end else begin
         if (expCtl[6] && expStallCnt != 4'hF) expStallCnt <= expStallCnt + 4'd1;
         if (expCtl[2] && expFlushCnt != 4'hF) expFlushCnt <= expFlushCnt + 4'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chkCtl(input string tag);
      chk({tag, ".ctl"}, {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, expCtl});
`ifdef HAZARD_PERF_CNT_EN
      chk({tag, ".stallCnt"}, {28'd0, stall_cnt}, {28'd0, expStallCnt});
      chk({tag, ".flushCnt"}, {28'd0, flush_cnt}, {28'd0, expFlushCnt});
`else
      chk({tag, ".stallCnt"}, {28'd0, stall_cnt}, 32'd0);
      chk({tag, ".flushCnt"}, {28'd0, flush_cnt}, 32'd0);
`endif
   endtask

   task automatic clearInputs();
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
      {PCSrcE, ResultSrcEb0, RegWriteM, RegWriteW, mem_req_m, mem_ready_m} = '0;
   endtask

   initial begin
      // Reset held with active-looking inputs: everything must read zero.
      reset = 1'b0;
      clearInputs();
      Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; mem_req_m = 1'b1; PCSrcE = 1'b1;
      #1;
      chkCtl("rst");
      chk("rst.fwdA", {30'd0, ForwardAE}, 32'd0);
      chk("rst.timeout", {31'd0, mem_timeout}, 32'd0);
      repeat (2) @(negedge clock);
      #1 chkCtl("rstHold");

      @(negedge clock);
      reset = 1'b1;
      clearInputs();
      #1 chkCtl("idle");

      // Forwarding priority and x0 suppression.
      Rs1E = 5'd5; Rs2E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
      #1 chk("fwdA.M", {30'd0, ForwardAE}, 32'd2);
      chk("fwdB.M", {30'd0, ForwardBE}, 32'd2);
      RdM = 5'd0;
      #1 chk("fwdA.W", {30'd0, ForwardAE}, 32'd1);
      chk("fwdB.W", {30'd0, ForwardBE}, 32'd1);
      Rs1E = 5'd0;
      #1 chk("fwdA.x0", {30'd0, ForwardAE}, 32'd0);
      RegWriteW = 1'b0;
      #1 chk("fwdB.noWr", {30'd0, ForwardBE}, 32'd0);
      RdM = 5'd5; RegWriteM = 1'b0; RegWriteW = 1'b1; Rs2E = 5'd5;
      #1 chk("fwdB.noWrM", {30'd0, ForwardBE}, 32'd1);
      clearInputs();

      // Load-use stall, then branch overriding it.
      @(negedge clock);
      ResultSrcEb0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7; expCtl = LW;
      #1 chkCtl("lwStall");
      @(negedge clock);
      PCSrcE = 1'b1; expCtl = BR;
      #1 chkCtl("lwBranch");
      @(negedge clock);
      ResultSrcEb0 = 1'b0; PCSrcE = 1'b0; RdE = 5'd0; Rs2D = 5'd0; expCtl = IDLE;
      #1 chkCtl("lwClear");

      // Memory wait for 3 cycles; branch and load-use ignored while frozen.
      @(negedge clock);
      mem_req_m = 1'b1; mem_ready_m = 1'b0; PCSrcE = 1'b1;
      ResultSrcEb0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7; expCtl = FRZ;
      #1 chkCtl("memWait0");
      @(negedge clock);
      PCSrcE = 1'b0; ResultSrcEb0 = 1'b0;
      #1 chkCtl("memWait1");
      @(negedge clock);
      #1 chkCtl("memWait2");
      @(negedge clock);
      mem_ready_m = 1'b1; expCtl = IDLE;
      #1 chkCtl("memReady");
      @(negedge clock);
      mem_req_m = 1'b0; mem_ready_m = 1'b0;
      #1 chkCtl("memIdle");

      // Timeout: ready never comes; ERR entered after 4 WAIT cycles.
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         mem_req_m = 1'b1; mem_ready_m = 1'b0; expCtl = FRZ;
         #1 chkCtl("toWait");
         chk("toWait.flag", {31'd0, mem_timeout}, 32'd0);
      end
      Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         mem_req_m = (i < 2) || (i == 3);
         mem_ready_m = (i == 3);
         #1 chkCtl("err");
         chk("err.flag", {31'd0, mem_timeout}, 32'd1);
         chk("err.fwdA", {30'd0, ForwardAE}, 32'd2);
      end

      // Asynchronous reset in ERR.
      @(negedge clock);
      #2 reset = 1'b0; expCtl = IDLE;
      #1 chkCtl("rstErr");
      chk("rstErr.flag", {31'd0, mem_timeout}, 32'd0);
      chk("rstErr.fwdA", {30'd0, ForwardAE}, 32'd0);
      @(negedge clock);
      reset = 1'b1; clearInputs();
      #1 chkCtl("postRstErr");
      chk("postRstErr.flag", {31'd0, mem_timeout}, 32'd0);

      // Asynchronous reset in WAIT.
      @(negedge clock);
      mem_req_m = 1'b1; expCtl = FRZ;
      #1 chkCtl("wait0");
      @(negedge clock);
      #1 chkCtl("wait1");
      #2 reset = 1'b0; expCtl = IDLE;
      #1 chkCtl("rstWait");
      @(negedge clock);
      reset = 1'b1; mem_req_m = 1'b0;
      #1 chkCtl("postRstWait");
      chk("postRstWait.flag", {31'd0, mem_timeout}, 32'd0);

      // Ready in the same cycle as request: no stall.
      @(negedge clock);
      mem_req_m = 1'b1; mem_ready_m = 1'b1;
      #1 chkCtl("sameCycle0");
      @(negedge clock);
      #1 chkCtl("sameCycle1");
      chk("sameCycle.flag", {31'd0, mem_timeout}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
